servant_gpio_in: RTL
====================

# servant_gpio_in

Wishbone-slave GPIO input port for the servant SoC: the receive-side counterpart of the existing GPIO output register that drives the `q` LEDs. Samples `NUM_GPIO` asynchronous external pins through a two-flop synchronizer and exposes the live level on the bus. Captures per-pin rising and falling edges into sticky write-1-to-clear pending bits, and raises a level interrupt for enabled pending bits. It sits on the servant data bus beside the output GPIO, at its own base address.

## Interface

Parameters:
- `NUM_GPIO`, default 8: number of input pins; valid range 1..32.

Ports:
- `i_clk`  in  1: single clock; all logic is on its rising edge.
- `i_rst_n`  in  1: synchronous, active-low reset.
- `i_wb_adr`  in  3: word address, bits [4:2] of the byte address.
- `i_wb_dat`  in  32: write data.
- `i_wb_we`  in  1: write enable.
- `i_wb_cyc`  in  1: cycle/strobe.
- `o_wb_rdt`  out  32: read data; valid while `o_wb_ack` is high.
- `o_wb_ack`  out  1: single-cycle acknowledge.
- `i_gpio`  in  `NUM_GPIO`: asynchronous external pins.
- `o_irq`  out  1: level interrupt.

## Operation

- Register map (word offset):
  - 0 DATA: read-only; returns the synchronized pin level. Writes are ignored.
  - 1 PENDING: read returns the pending bits. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
  - 2 RISE_EN: read/write; per-pin rising-edge capture enable.
  - 3 FALL_EN: read/write; per-pin falling-edge capture enable.
  - 4 IRQ_EN: read/write; per-pin interrupt enable.
  - Offsets 5–7: reads return 0; writes are ignored.
- Bits at or above `NUM_GPIO` read as 0 in every register.
- Synchronizer:
  - `sync1 <= i_gpio`, `sync2 <= sync1`, `prev <= sync2`.
  - DATA is `sync2`.
- Edge event per bit:
  - Rising: `sync2 & ~prev & RISE_EN`.
  - Falling: `~sync2 & prev & FALL_EN`.
- Pending update per bit: `pending <= (pending & ~clr) | event`.
  - `clr` is the PENDING write data when a PENDING write is acknowledged in this cycle, else 0.
  - Set wins over a simultaneous clear.
- Arming counter, 2 bits:
  - Resets to 0 and counts up to 3, then saturates.
  - Edge events are suppressed while the counter is below 3. This prevents pins held high through reset from registering false rising edges.
- `o_irq = |(pending & IRQ_EN)`, combinational from registers.
- Bus handshake:
  - `o_wb_ack <= i_wb_cyc & ~o_wb_ack`, giving exactly one ack per access and ack low for at least one cycle between accesses.
  - Write side effects take effect on the clock edge that raises ack.
  - `o_wb_rdt` is registered on that same edge and is 0 when ack is low.
- Reset values: `sync1`, `sync2`, `prev`, pending, RISE_EN, FALL_EN, IRQ_EN, arming counter, `o_wb_ack`, `o_wb_rdt`, `o_irq` are all 0.
- Reset mid-access: ack is dropped and all register state returns to reset values. No write completes in the reset cycle.

## Timing

- A pin change stable before edge N appears in `sync2`, and therefore in DATA, after edge N+1.
- The corresponding pending bit sets at edge N+2, and `o_irq` rises in the same cycle if enabled.
- Bus latency: ack and read data arrive one cycle after `i_wb_cyc` is first sampled high.
- A DATA read returns the `sync2` value present at the ack edge.
- A PENDING clear is visible on the next read. `o_irq` falls in the cycle after the clearing ack edge unless a new event sets the bit again.
- Back-to-back `cyc` produces ack on alternate cycles.
- First edge capture is possible 3 cycles after `i_rst_n` goes high. Edges in cycles 1–3 after reset are discarded.

## Test plan

- Reset with `i_gpio`=0xFF held high throughout: DATA reads 0xFF, PENDING reads 0x00, `o_irq`=0; all registers read 0 before reads of DATA settle.
- RISE_EN=0x01, IRQ_EN=0x01, then toggle `i_gpio[0]` 0→1: PENDING=0x01 exactly 3 cycles after the pin change; `o_irq`=1. Write PENDING=0x01: PENDING=0x00 and `o_irq`=0 one cycle after ack.
- FALL_EN=0x80, RISE_EN=0: pulse `i_gpio[7]` 1→0→1 with the level held ≥3 cycles: only the falling edge sets PENDING[7]; with IRQ_EN=0 the pending bit is set and `o_irq` stays 0.
- Arrange a new rising edge on bit 2 to land in the same cycle as a W1C write of 0x04: PENDING[2] remains 1.
- Write 0xFFFFFFFF to offsets 2, 3, 4 and read back: each returns 0x000000FF. Offset 6 reads 0 and writes there change nothing. `cyc` held high for 4 cycles yields ack pattern 0,1,0,1.
- Assert `i_rst_n`=0 in the cycle `cyc` rises on a write of IRQ_EN=0xFF: no ack is produced and IRQ_EN reads 0 after reset.

Source files
------------

// File: rtl/servant_gpio_in.sv
// Wishbone GPIO input port: synchronized pin levels, sticky edge-pending bits
// with write-1-to-clear, and a level interrupt for enabled pending bits.
module servant_gpio_in #(
    parameter int unsigned NUM_GPIO = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [2:0]          i_wb_adr,
    input  logic [31:0]         i_wb_dat,
    input  logic                i_wb_we,
    input  logic                i_wb_cyc,
    output logic [31:0]         o_wb_rdt,
    output logic                o_wb_ack,
    input  logic [NUM_GPIO-1:0] i_gpio,
    output logic                o_irq
);

    logic [NUM_GPIO-1:0] sync1;
    logic [NUM_GPIO-1:0] sync2;
    logic [NUM_GPIO-1:0] prev;
    logic [NUM_GPIO-1:0] pending;
    logic [NUM_GPIO-1:0] rise_en;
    logic [NUM_GPIO-1:0] fall_en;
    logic [NUM_GPIO-1:0] irq_en;
    logic [1:0]          arm_cnt;

    logic                access;
    logic                wr;
    logic [NUM_GPIO-1:0] events;
    logic [NUM_GPIO-1:0] clr;
    logic [31:0]         rd_word;
    logic                unused_dat;

    // Data bits above NUM_GPIO have no destination.
    assign unused_dat = ^i_wb_dat;

    assign access = i_wb_cyc & ~o_wb_ack;
    assign wr     = access & i_wb_we;

    // Edges are ignored until the synchronizer chain has flushed after reset.
    always_comb begin
        events = '0;
        if (arm_cnt == 2'd3) begin
            events = (sync2 & ~prev & rise_en) | (~sync2 & prev & fall_en);
        end
    end

    always_comb begin
        clr = '0;
        if (wr && (i_wb_adr == 3'd1)) begin
            clr = i_wb_dat[NUM_GPIO-1:0];
        end
    end

    always_comb begin
        rd_word = '0;
        case (i_wb_adr)
            3'd0:    rd_word[NUM_GPIO-1:0] = sync2;
            3'd1:    rd_word[NUM_GPIO-1:0] = pending;
            3'd2:    rd_word[NUM_GPIO-1:0] = rise_en;
            3'd3:    rd_word[NUM_GPIO-1:0] = fall_en;
            3'd4:    rd_word[NUM_GPIO-1:0] = irq_en;
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            pending  <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            irq_en   <= '0;
            arm_cnt  <= '0;
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
        end else begin
            sync1 <= i_gpio;
            sync2 <= sync1;
            prev  <= sync2;
            if (arm_cnt != 2'd3) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
            // A new event wins over a simultaneous clear.
            pending <= (pending & ~clr) | events;
            if (wr) begin
                case (i_wb_adr)
                    3'd2:    rise_en <= i_wb_dat[NUM_GPIO-1:0];
                    3'd3:    fall_en <= i_wb_dat[NUM_GPIO-1:0];
                    3'd4:    irq_en  <= i_wb_dat[NUM_GPIO-1:0];
                    default: ;
                endcase
            end
            o_wb_ack <= access;
            o_wb_rdt <= access ? rd_word : '0;
        end
    end

    assign o_irq = |(pending & irq_en);

endmodule
